fft_peak_analysis: RTL and testbench

Consumer-side block for the FFT output bus. It captures one parallel 16-bin frame (`fft_d0`..`fft_d15`) when `fft_valid` is asserted and scans the bins sequentially, one per clock, computing the squared magnitude of each bin. It reports the index of the strongest bin on `freq` with a one-cycle `done` pulse. It sits directly downstream of the FFT, closing the FIR -> FFT -> analysis chain of the frequency analysis system.

---
 rtl/fft_peak_analysis_if.sv | 22 ++
 rtl/fft_peak_analysis.sv | 69 ++++++
 tb/tb_fft_peak_analysis.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/fft_peak_analysis_if.sv
// fft_peak_analysis_if: FFT output bus from the FFT to the peak analysis block.
// ANALYSIS_MAG_OUT_EN adds the max_mag result signal.
interface fft_peak_analysis_if #(parameter int NBINS = 16, parameter int DW = 16);
  logic                fft_valid;
  logic [2*DW-1:0]     fft_d [NBINS];
  logic                done;
  logic [3:0]          freq;
  logic                busy;
`ifdef ANALYSIS_MAG_OUT_EN
  logic [2*DW-1:0]     max_mag;
`endif
  modport master(output fft_valid, fft_d, input done, freq, busy
`ifdef ANALYSIS_MAG_OUT_EN
    , input max_mag
`endif
  );
  modport slave(input fft_valid, fft_d, output done, freq, busy
`ifdef ANALYSIS_MAG_OUT_EN
    , output max_mag
`endif
  );
endinterface

// File: rtl/fft_peak_analysis.sv
// fft_peak_analysis: captures a 16-bin FFT frame and reports the index of the strongest bin.
// ANALYSIS_MAG_OUT_EN exposes the winning squared magnitude on max_mag.
module fft_peak_analysis #(parameter int NBINS = 16, parameter int DW = 16) (
  input logic clk,
  input logic rst,
  fft_peak_analysis_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t             r_state, w_next;
  logic [2*DW-1:0]    r_buf [NBINS];
  logic [3:0]         r_idx, r_best_idx, r_freq;
  logic [31:0]        r_best_mag;
  logic signed [DW-1:0] w_re, w_im;
  logic signed [31:0] w_pr, w_pi;
  logic [31:0]        w_mag;
  logic               w_upd, w_start, w_last;
`ifdef ANALYSIS_MAG_OUT_EN
  logic [31:0]        r_max_mag;
  assign bus.max_mag = r_max_mag;
`endif
  assign w_re = r_buf[r_idx][2*DW-1:DW];
  assign w_im = r_buf[r_idx][DW-1:0];
  assign w_pr = w_re * w_re;
  assign w_pi = w_im * w_im;
  // sum peaks at 2^31 for (-32768,-32768), so unsigned 32 bits never overflows
  assign w_mag = $unsigned(w_pr) + $unsigned(w_pi);
  assign w_upd = w_mag > r_best_mag;
  assign w_last = r_idx == 4'd15;
  assign w_start = r_state != SCAN && bus.fft_valid;
  always_comb begin
    w_next = r_state;
    w_next = r_state == SCAN ? (w_last ? DONE : SCAN) : (bus.fft_valid ? SCAN : IDLE);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_idx <= '0;
      r_best_idx <= '0;
      r_best_mag <= '0;
      r_freq <= '0;
`ifdef ANALYSIS_MAG_OUT_EN
      r_max_mag <= '0;
`endif
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_buf <= bus.fft_d;
        r_idx <= '0;
        r_best_idx <= '0;
        r_best_mag <= '0;
      end else if (r_state == SCAN) begin
        r_idx <= r_idx + 4'd1;
        if (w_upd) begin
          r_best_mag <= w_mag;
          r_best_idx <= r_idx;
        end
        if (w_last) begin
          r_freq <= w_upd ? r_idx : r_best_idx;
`ifdef ANALYSIS_MAG_OUT_EN
          r_max_mag <= w_upd ? w_mag : r_best_mag;
`endif
        end
      end
    end
  end
  assign bus.done = r_state == DONE;
  assign bus.busy = r_state == SCAN;
  assign bus.freq = r_freq;
endmodule

// File: tb/tb_fft_peak_analysis.sv
// tb_fft_peak_analysis: directed frames with hand-computed peak indices and latencies.
module tb_fft_peak_analysis;
  logic clk = 0;
  logic rst = 0;
  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] fr [16];
  fft_peak_analysis_if bus();
  fft_peak_analysis dut(.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %h expected %h", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clear_frame;
    for (int i = 0; i < 16; i++) fr[i] = '0;
  endtask
  task automatic start;
    bus.fft_d = fr;
    bus.fft_valid = 1;
    tick;
    bus.fft_valid = 0;
  endtask
  task automatic wait_done(input string tag, input int exp_lat);
    int n = 0;
    while (!bus.done && n < 40) begin
      tick;
      n++;
    end
    chk(tag, n, exp_lat);
  endtask
  initial begin
    int cnt;
    bus.fft_valid = 0;
    clear_frame;
    bus.fft_d = fr;
    repeat (3) tick;
    chk("rst_done", bus.done, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_freq", bus.freq, 0);
`ifdef ANALYSIS_MAG_OUT_EN
    chk("rst_mag", bus.max_mag, 0);
`endif
    rst = 1;
    repeat (5) tick;
    chk("idle_done", bus.done, 0);
    chk("idle_busy", bus.busy, 0);
    chk("idle_freq", bus.freq, 0);
    // single peak
    clear_frame;
    fr[5] = 32'h0100_0000;
    start;
    chk("peak_busy", bus.busy, 1);
    wait_done("peak_lat", 16);
    chk("peak_freq", bus.freq, 5);
    chk("peak_busy_fall", bus.busy, 0);
`ifdef ANALYSIS_MAG_OUT_EN
    chk("peak_mag", bus.max_mag, 32'h0001_0000);
`endif
    tick;
    chk("peak_done_pulse", bus.done, 0);
    chk("peak_freq_hold", bus.freq, 5);
    // tie and sign
    clear_frame;
    fr[3] = 32'hFF00_0000;
    fr[11] = 32'h0000_0100;
    start;
    wait_done("tie_lat", 16);
    chk("tie_freq", bus.freq, 3);
`ifdef ANALYSIS_MAG_OUT_EN
    chk("tie_mag", bus.max_mag, 32'h0001_0000);
`endif
    tick;
    // extremes
    for (int i = 0; i < 16; i++) fr[i] = 32'h7FFF_0000;
    fr[9] = 32'h8000_8000;
    start;
    wait_done("ext_lat", 16);
    chk("ext_freq", bus.freq, 9);
`ifdef ANALYSIS_MAG_OUT_EN
    chk("ext_mag", bus.max_mag, 32'h8000_0000);
`endif
    tick;
    clear_frame;
    start;
    wait_done("zero_lat", 16);
    chk("zero_freq", bus.freq, 0);
`ifdef ANALYSIS_MAG_OUT_EN
    chk("zero_mag", bus.max_mag, 0);
`endif
    tick;
    // frame during scan is dropped, back-to-back capture in DONE
    clear_frame;
    fr[7] = 32'h0100_0000;
    start;
    repeat (7) tick;
    clear_frame;
    fr[2] = 32'h0200_0000;
    start;
    wait_done("hs_lat", 8);
    chk("hs_freq", bus.freq, 7);
    clear_frame;
    fr[12] = 32'h0000_0300;
    start;
    chk("b2b_busy", bus.busy, 1);
    chk("b2b_freq_hold", bus.freq, 7);
    wait_done("b2b_lat", 16);
    chk("b2b_freq", bus.freq, 12);
    tick;
    chk("b2b_done_pulse", bus.done, 0);
    chk("b2b_idle", bus.busy, 0);
    // reset mid-scan
    clear_frame;
    fr[4] = 32'h0100_0100;
    start;
    repeat (9) tick;
    rst = 0;
    tick;
    chk("mid_busy", bus.busy, 0);
    chk("mid_done", bus.done, 0);
    chk("mid_freq", bus.freq, 0);
    rst = 1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (bus.done) cnt++;
    end
    chk("mid_nodone", cnt, 0);
    clear_frame;
    fr[14] = 32'hFFF0_0010;
    fr[1] = 32'h0000_0010;
    start;
    wait_done("post_lat", 16);
    chk("post_freq", bus.freq, 14);
    tick;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
